pipelined_adder: RTL

//  Pipelined WIDTH-bit adder with a valid handshake. It sits between the BRAM-driven

---
 rtl/pipelined_adder.sv | 106 ++++++++++
 1 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder
//   WIDTH-bit adder split into STAGES equal carry-chained slices, one register
//   stage per slice. Full throughput (one transaction per cycle), latency of
//   exactly STAGES cycles, no backpressure.
//
// Ports
//   clk        clock, all state on the rising edge
//   rstn       synchronous reset, active-low
//   a, b       operands, sampled when valid_in=1
//   cin        carry into bit 0, sampled when valid_in=1
//   valid_in   transaction strobe
//   s          sum (a+b+cin)[WIDTH-1:0], holds the last completed result
//   cout       carry out of bit WIDTH-1, holds with s
//   valid_out  one-cycle strobe per completed transaction
module pipelined_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             valid_in,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             valid_out
);

    localparam int unsigned C = WIDTH / STAGES;

    if (WIDTH % STAGES != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH (%0d) must be a multiple of STAGES (%0d)",
               WIDTH, STAGES);
    end

    // Stage k receives the operand bits from slice k upward (re-based to bit 0)
    // and the sum bits of slices below k. It adds the lowest C operand bits,
    // appends them to the partial sum and forwards the still-unused operand bits.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned IW = WIDTH - k * C;  // operand bits entering stage
        localparam int unsigned SW = (k + 1) * C;    // sum bits leaving stage

        logic [IW-1:0] opa_in;
        logic [IW-1:0] opb_in;
        logic          carry_in;
        logic          v_in;
        logic [C:0]    res;
        logic [SW-1:0] sum_d;
        logic [SW-1:0] sum_q;
        logic          carry_q;
        logic          valid_q;

        if (k == 0) begin : g_first
            assign opa_in   = a;
            assign opb_in   = b;
            assign carry_in = cin;
            assign v_in     = valid_in;
            assign sum_d    = res[C-1:0];
        end else begin : g_next
            assign opa_in   = g_stage[k-1].g_ops.opa_q;
            assign opb_in   = g_stage[k-1].g_ops.opb_q;
            assign carry_in = g_stage[k-1].carry_q;
            assign v_in     = g_stage[k-1].valid_q;
            assign sum_d    = {res[C-1:0], g_stage[k-1].sum_q};
        end

        assign res = {1'b0, opa_in[C-1:0]} + {1'b0, opb_in[C-1:0]} + {{C{1'b0}}, carry_in};

        // Data only loads behind a valid bit, so the final stage holds the
        // last completed result while valid_out is low.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= v_in;
                if (v_in) begin
                    sum_q   <= sum_d;
                    carry_q <= res[C];
                end
            end
        end

        if (IW > C) begin : g_ops
            logic [IW-C-1:0] opa_q;
            logic [IW-C-1:0] opb_q;

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else if (v_in) begin
                    opa_q <= opa_in[IW-1:C];
                    opb_q <= opb_in[IW-1:C];
                end
            end
        end
    end

    assign s         = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].carry_q;
    assign valid_out = g_stage[STAGES-1].valid_q;

endmodule
